// File: rtl/blink_rate_detector.sv
// blink_rate_detector: classifies a square-wave input's half-period as 10/5/2/1 Hz.
// Optional stability filter on the synchronized input: define BLINK_DET_GLITCH_FILTER_EN.
module blink_rate_detector #(
    parameter logic [31:0] HALF_10HZ  = 32'd1200001,
    parameter logic [31:0] HALF_5HZ   = 32'd2400001,
    parameter logic [31:0] HALF_2HZ   = 32'd6000001,
    parameter logic [31:0] HALF_1HZ   = 32'd12000001,
    parameter int          TOL_SHIFT  = 4,
    parameter logic [31:0] TIMEOUT    = 32'd24000000,
    parameter int          FILTER_LEN = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_blink,
    output logic [2:0] o_rate,
    output logic       o_locked,
    output logic       o_change
);

    typedef enum logic [1:0] {IDLE, ARMED, CAND, LOCKED} state_t;

    // The timeout must outlast the slowest accepted half-period.
    if (TIMEOUT <= HALF_1HZ + (HALF_1HZ >> TOL_SHIFT) || FILTER_LEN < 1) begin : g_bad_cfg
        $error("blink_rate_detector: TIMEOUT too small or FILTER_LEN < 1");
    end

    logic        s1_q, s2_q, hist_q, lvl, edge_det;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  cls, cand_q, cand_d, rate_q, rate_d;
    logic        locked_q, change_q;
    state_t      state_q, state_d;

    function automatic logic hit(input logic [31:0] iv, input logic [31:0] half);
        logic [31:0] tol;
        tol = half >> TOL_SHIFT;
        return (iv >= half - tol) && (iv <= half + tol);
    endfunction

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= i_blink;
            s2_q <= s1_q;
        end
    end

`ifdef BLINK_DET_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic          lvl_q;
    logic [FW-1:0] fcnt_q;
    // Accept a new level only once it has been stable for FILTER_LEN samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lvl_q  <= 1'b0;
            fcnt_q <= '0;
        end else if (s2_q == lvl_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            lvl_q  <= s2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end
    assign lvl = lvl_q;
`else
    assign lvl = s2_q;
`endif

    assign edge_det = lvl ^ hist_q;
    assign cnt_d    = edge_det ? 32'd1 : (cnt_q < TIMEOUT ? cnt_q + 32'd1 : cnt_q);

    // History flop and interval counter; cnt_q on an edge cycle is the interval just ended.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= lvl;
            cnt_q  <= cnt_d;
        end
    end

    // Map the measured interval to a rate code; windows are disjoint for sane parameters.
    always_comb begin
        cls = hit(cnt_q, HALF_10HZ) ? 3'd4 :
              hit(cnt_q, HALF_5HZ)  ? 3'd3 :
              hit(cnt_q, HALF_2HZ)  ? 3'd2 :
              hit(cnt_q, HALF_1HZ)  ? 3'd1 : 3'd0;
    end

    // Lock FSM: two matching intervals confirm a rate; edges take priority over timeout.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        rate_d  = rate_q;
        if (edge_det) begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (cls != 3'd0) begin
                        state_d = CAND;
                        cand_d  = cls;
                    end
                end
                CAND: begin
                    if (cls == 3'd0) begin
                        state_d = ARMED;
                    end else if (cls == cand_q) begin
                        state_d = LOCKED;
                        rate_d  = cls;
                    end else begin
                        cand_d = cls;
                    end
                end
                default: begin
                    if (cls != rate_q) begin
                        state_d = (cls == 3'd0) ? ARMED : CAND;
                        cand_d  = cls;
                        rate_d  = 3'd0;
                    end
                end
            endcase
        end else if (state_q != IDLE && cnt_q == TIMEOUT) begin
            state_d = IDLE;
            rate_d  = 3'd0;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cand_q   <= 3'd0;
            rate_q   <= 3'd0;
            locked_q <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            rate_q   <= rate_d;
            locked_q <= (state_d == LOCKED);
            change_q <= (rate_d != rate_q);
        end
    end

    assign o_rate   = rate_q;
    assign o_locked = locked_q;
    assign o_change = change_q;

endmodule
